uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 Parameter TX_DEPTH, default 4, power of two >=2: TX FIFO depth in bytes.
REQ-002 Parameter BASE, default 32'h40000018: address of the TX data register; RX data is at BASE+4 and control/status (CON) at BASE+8.
REQ-003 sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  32  CPU byte address.
REQ-006 mem_read  in  1  CPU read strobe, one cycle per access.
REQ-007 mem_write  in  1  CPU write strobe, one cycle per access.
REQ-008 write_data  in  32  CPU write data.
REQ-009 read_data  out  32  CPU read data.
REQ-010 irq  out  1  interrupt request, level.
REQ-011 RX_DATA  in  8  received byte from the UART receiver.
REQ-012 RX_STATUS  in  1  receiver byte-valid; may stay high for more than one cycle.
REQ-013 TX_STATUS  in  1  sender idle (1) / busy (0).
REQ-014 TX_DATA  out  8  byte to the sender.
REQ-015 TX_EN  out  1  sender start, one-cycle pulse.

Function
REQ-016 read_data SHALL be combinational: while mem_read=1, it carries the addressed register; otherwise it is 0; unmapped addresses read 0.
REQ-017 Register side effects SHALL take effect at the clock edge where the strobe is high; writes to unmapped addresses SHALL be ignored.
REQ-018 A write to BASE SHALL push write_data[7:0] into the TX FIFO if count<TX_DEPTH or a pop occurs in the same cycle; otherwise the byte is dropped and CON[7] tx_overflow is set.
REQ-019 The TX FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_DONE.
REQ-020 IDLE->SEND when the FIFO is non-empty and TX_STATUS=1; at that edge, load TX_DATA with the head byte and pop the FIFO.
REQ-021 In SEND, TX_EN=1 for exactly one cycle, then go unconditionally to WAIT_BUSY.
REQ-022 WAIT_BUSY->WAIT_DONE when TX_STATUS=0; WAIT_DONE->IDLE when TX_STATUS=1.
REQ-023 TX_DATA SHALL hold stable from SEND until the next load.
REQ-024 On the WAIT_DONE->IDLE transition, if the FIFO is empty, set CON[2] tx_done.
REQ-025 Minimum latency from a TX write on an empty FIFO with idle sender: TX_EN high 2 cycles after the write edge.
REQ-026 On a rising edge of RX_STATUS (registered previous value 0, current 1), capture RX_DATA into rx_buf and set rx_valid (CON[3]).
REQ-027 If a capture occurs while rx_valid=1, rx_buf is overwritten and CON[6] rx_overrun is set.
REQ-028 A read of BASE+4 SHALL return {24'b0, rx_buf} and clear rx_valid.
REQ-029 If a capture and a BASE+4 read occur in the same cycle, the read returns the old rx_buf and rx_valid ends at 1.
REQ-030 CON read value: [0] tx_irq_en, [1] rx_irq_en, [2] tx_done, [3] rx_valid, [4] tx_busy (state!=IDLE or FIFO non-empty), [5] tx_full, [6] rx_overrun, [7] tx_overflow, [31:8] 0.
REQ-031 A read of CON SHALL clear bits 2, 6 and 7 after returning them.
REQ-032 A set event coinciding with a CON read SHALL win, leaving the bit set.
REQ-033 A write to CON SHALL update only bits [1:0].
REQ-034 irq = (CON[0] & tx_done) | (CON[1] & rx_valid), registered-free combinational output from flags.
REQ-035 FIFO pointers SHALL wrap modulo TX_DEPTH; count width is log2(TX_DEPTH)+1.

Reset
REQ-036 While reset=1 at an edge: FIFO empty, state IDLE, TX_EN=0, TX_DATA=0, rx_buf=0, all CON bits 0, previous-RX_STATUS register 0; irq=0 and read_data=0 absent mem_read.
REQ-037 Reset during SEND SHALL force TX_EN=0 from the next cycle; a byte already accepted by the sender is not recalled.

Verification
REQ-038 Write 0x41 to BASE with the sender idle -> TX_EN pulses one cycle 2 cycles later with TX_DATA=0x41; after TX_STATUS goes 0 then 1, CON reads 0x04, then a second read returns 0x00.
REQ-039 With TX_STATUS held 0, write 5 bytes to BASE -> first 4 queued, CON=0x B0 (busy, full, overflow); release TX_STATUS -> 4 TX_EN pulses in FIFO order.
REQ-040 Hold RX_STATUS high 3 cycles with RX_DATA=0x5A -> exactly one capture; read BASE+4 returns 0x0000005A; CON[3] becomes 0.
REQ-041 Two RX captures (0x11, 0x22) without a read -> BASE+4 returns 0x22 and CON[6]=1; with CON[1:0]=2'b10, irq=1 until the data read.
REQ-042 Capture coincident with a BASE+4 read -> old byte returned, rx_valid still 1, new byte read next.
REQ-043 Assert reset in SEND with 3 bytes queued -> TX_EN=0 next cycle, CON reads 0, no further TX_EN.

Source files
------------

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX byte FIFO feeding a start/busy handshake FSM,
// a single-byte RX buffer, and a control/status register with interrupt flags.
module uart_mmio #(
    parameter int unsigned TX_DEPTH = 4,
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STATUS,
    input  logic        TX_STATUS,
    output logic [7:0]  TX_DATA,
    output logic        TX_EN
);

    localparam int unsigned   PTR_W    = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = TX_DEPTH[PTR_W:0];
    localparam logic [31:0]   ADDR_TX  = BASE;
    localparam logic [31:0]   ADDR_RX  = BASE + 32'd4;
    localparam logic [31:0]   ADDR_CON = BASE + 32'd8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

    tx_state_e        state_q;
    logic [7:0]       tx_data_q;
    logic             tx_en_q;

    logic [7:0]       fifo_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [7:0]       rx_buf_q, rx_buf_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             rx_status_prev_q;
    logic             tx_done_q, tx_done_d;
    logic             tx_overflow_q, tx_overflow_d;
    logic [1:0]       irq_en_q, irq_en_d;

    logic tx_wr, con_wr, rx_rd, con_rd;
    logic fifo_empty, fifo_full, push, pop;
    logic overflow_set, done_set, rx_capture, tx_busy;
    logic [31:0] con_value;
    logic unused_wdata;

    assign tx_wr  = mem_write && (addr == ADDR_TX);
    assign con_wr = mem_write && (addr == ADDR_CON);
    assign rx_rd  = mem_read  && (addr == ADDR_RX);
    assign con_rd = mem_read  && (addr == ADDR_CON);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = (state_q == IDLE) && !fifo_empty && TX_STATUS;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push         = tx_wr && (!fifo_full || pop);
    assign overflow_set = tx_wr && !push;
    assign done_set     = (state_q == WAIT_DONE) && TX_STATUS && fifo_empty;
    assign rx_capture   = RX_STATUS && !rx_status_prev_q;
    assign tx_busy      = (state_q != IDLE) || !fifo_empty;

    assign con_value = {24'd0, tx_overflow_q, rx_overrun_q, fifo_full, tx_busy,
                        rx_valid_q, tx_done_q, irq_en_q};

    assign irq          = (irq_en_q[0] & tx_done_q) | (irq_en_q[1] & rx_valid_q);
    assign TX_DATA      = tx_data_q;
    assign TX_EN        = tx_en_q;
    assign unused_wdata = ^write_data[31:8];

    always_comb begin
        read_data = 32'd0;
        if (mem_read) begin
            case (addr)
                ADDR_RX:  read_data = {24'd0, rx_buf_q};
                ADDR_CON: read_data = con_value;
                default:  read_data = 32'd0;
            endcase
        end
    end

    // NOTE: every output of a combinational block is assigned a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set events take priority over the clear-on-read of the same bit.
        tx_done_d     = done_set | (tx_done_q & ~con_rd);
        tx_overflow_d = overflow_set | (tx_overflow_q & ~con_rd);
        rx_overrun_d  = (rx_capture & rx_valid_q) | (rx_overrun_q & ~con_rd);
        rx_valid_d    = rx_capture | (rx_valid_q & ~rx_rd);
        rx_buf_d      = rx_capture ? RX_DATA : rx_buf_q;
        irq_en_d      = con_wr ? write_data[1:0] : irq_en_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            rx_buf_q         <= '0;
            rx_valid_q       <= 1'b0;
            rx_overrun_q     <= 1'b0;
            rx_status_prev_q <= 1'b0;
            tx_done_q        <= 1'b0;
            tx_overflow_q    <= 1'b0;
            irq_en_q         <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            rx_buf_q         <= rx_buf_d;
            rx_valid_q       <= rx_valid_d;
            rx_overrun_q     <= rx_overrun_d;
            rx_status_prev_q <= RX_STATUS;
            tx_done_q        <= tx_done_d;
            tx_overflow_q    <= tx_overflow_d;
            irq_en_q         <= irq_en_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= write_data[7:0];
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= fifo_mem_q[rd_ptr_q];
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    tx_en_q <= 1'b1;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: if (!TX_STATUS) state_q <= WAIT_DONE;
                WAIT_DONE: if (TX_STATUS)  state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: TX latency and ordering, overflow, RX capture,
// overrun, coincident read/capture, interrupts and reset during a send.
module tb_uart_mmio;

    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_RX  = BASE + 32'd4;
    localparam logic [31:0] A_CON = BASE + 32'd8;
    localparam logic [31:0] A_BAD = BASE + 32'd12;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        irq;
    logic [7:0]  RX_DATA;
    logic        RX_STATUS;
    logic        TX_STATUS;
    logic [7:0]  TX_DATA;
    logic        TX_EN;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic [7:0]  tx_log [$];

    always #5 sys_clk = ~sys_clk;

    uart_mmio #(.TX_DEPTH(4), .BASE(BASE)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .addr       (addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .read_data  (read_data),
        .irq        (irq),
        .RX_DATA    (RX_DATA),
        .RX_STATUS  (RX_STATUS),
        .TX_STATUS  (TX_STATUS),
        .TX_DATA    (TX_DATA),
        .TX_EN      (TX_EN)
    );

    // Every cycle with TX_EN high records the byte offered to the sender.
    always @(negedge sys_clk) begin
        if (TX_EN === 1'b1) tx_log.push_back(TX_DATA);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write_data = d;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr     = a;
        mem_read = 1'b1;
        #1;
        d = read_data;
        tick();
        mem_read = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        RX_DATA   = b;
        RX_STATUS = 1'b1;
        tick();
        RX_STATUS = 1'b0;
        tick();
    endtask

    task automatic wait_tx_en(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (TX_EN === 1'b1) seen = 1'b1;
            else tick();
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        addr       = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        write_data = '0;
        RX_DATA    = '0;
        RX_STATUS  = 1'b0;
        TX_STATUS  = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_tx_en", {31'd0, TX_EN}, 32'd0);
        check("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        reset = 1'b0;
        tick();
        bus_read(A_CON, rd);
        check("rst_con", rd, 32'h0);
        bus_read(A_RX, rd);
        check("rst_rx", rd, 32'h0);

        // Single byte: TX_EN two edges after the write edge, then tx_done
        tx_log.delete();
        bus_write(A_TX, 32'h41);
        check("tx1_en_e0", {31'd0, TX_EN}, 32'd0);
        tick();
        check("tx1_en_e1", {31'd0, TX_EN}, 32'd0);
        check("tx1_data_e1", {24'd0, TX_DATA}, 32'h41);
        tick();
        check("tx1_en_e2", {31'd0, TX_EN}, 32'd1);
        check("tx1_data_e2", {24'd0, TX_DATA}, 32'h41);
        tick();
        check("tx1_en_e3", {31'd0, TX_EN}, 32'd0);
        TX_STATUS = 1'b0;
        repeat (2) tick();
        TX_STATUS = 1'b1;
        tick();
        bus_read(A_CON, rd);
        check("tx1_con_done", rd, 32'h04);
        bus_read(A_CON, rd);
        check("tx1_con_clr", rd, 32'h00);
        check("tx1_pulses", tx_log.size(), 32'd1);

        // Five writes with a busy sender: four queued, one dropped
        tx_log.delete();
        TX_STATUS = 1'b0;
        for (int i = 1; i <= 5; i++) bus_write(A_TX, 32'(i));
        bus_read(A_CON, rd);
        check("ovf_con", rd, 32'hB0);
        bus_read(A_CON, rd);
        check("ovf_con_clr", rd, 32'h30);
        bus_write(A_CON, 32'h1);
        TX_STATUS = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tx_en($sformatf("ovf_tx_en_%0d", i));
            TX_STATUS = 1'b0;
            tick();
            TX_STATUS = 1'b1;
            tick();
        end
        repeat (3) tick();
        check("ovf_pulses", tx_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < tx_log.size()) check($sformatf("ovf_order_%0d", i), {24'd0, tx_log[i]}, 32'(i + 1));
        end
        check("tx_irq_set", {31'd0, irq}, 32'd1);
        bus_read(A_CON, rd);
        check("ovf_con_done", rd, 32'h05);
        check("tx_irq_clr", {31'd0, irq}, 32'd0);
        bus_write(A_CON, 32'h0);

        // RX_STATUS held three cycles gives exactly one capture
        RX_DATA   = 8'h5A;
        RX_STATUS = 1'b1;
        repeat (3) tick();
        RX_STATUS = 1'b0;
        tick();
        bus_read(A_CON, rd);
        check("rx1_con", rd, 32'h08);
        bus_read(A_RX, rd);
        check("rx1_data", rd, 32'h5A);
        bus_read(A_CON, rd);
        check("rx1_con_clr", rd, 32'h00);

        // CON write masks to [1:0]; unmapped accesses are inert
        bus_write(A_CON, 32'hFFFF_FFFF);
        bus_write(A_BAD, 32'hFFFF_FFFF);
        bus_read(A_CON, rd);
        check("con_wmask", rd, 32'h03);
        bus_read(A_BAD, rd);
        check("unmapped_rd", rd, 32'h0);
        addr = A_CON;
        #1;
        check("rdata_idle", read_data, 32'h0);
        bus_write(A_CON, 32'h2);

        // Overrun with RX interrupt enabled
        rx_pulse(8'h11);
        check("rx_irq_1", {31'd0, irq}, 32'd1);
        rx_pulse(8'h22);
        bus_read(A_CON, rd);
        check("ovr_con", rd, 32'h4A);
        check("rx_irq_2", {31'd0, irq}, 32'd1);
        bus_read(A_RX, rd);
        check("ovr_data", rd, 32'h22);
        check("rx_irq_clr", {31'd0, irq}, 32'd0);

        // Capture coincident with a data read
        rx_pulse(8'h33);
        RX_DATA   = 8'h44;
        RX_STATUS = 1'b1;
        bus_read(A_RX, rd);
        RX_STATUS = 1'b0;
        check("coin_old", rd, 32'h33);
        check("coin_irq", {31'd0, irq}, 32'd1);
        bus_read(A_CON, rd);
        check("coin_con", rd, 32'h4A);
        bus_read(A_RX, rd);
        check("coin_new", rd, 32'h44);
        bus_read(A_CON, rd);
        check("coin_con_clr", rd, 32'h02);
        bus_write(A_CON, 32'h0);

        // Reset while in SEND with three bytes still queued
        TX_STATUS = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(A_TX, 32'hA0 + 32'(i));
        tx_log.delete();
        TX_STATUS = 1'b1;
        tick();
        check("rsend_data", {24'd0, TX_DATA}, 32'hA0);
        reset = 1'b1;
        tick();
        check("rsend_tx_en", {31'd0, TX_EN}, 32'd0);
        reset = 1'b0;
        bus_read(A_CON, rd);
        check("rsend_con", rd, 32'h0);
        repeat (10) tick();
        check("rsend_pulses", tx_log.size(), 32'd0);
        check("rsend_tx_data", {24'd0, TX_DATA}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
